z3_master_cycle: RTL and testbench

Zorro III bus-master cycle sequencer for the A4091 DMA path. Accepts one transfer request at a time from the local SCSI DMA master in 68030 form (SIZ/A1:A0, read/write), converts it into a Zorro III master cycle (FCS, byte strobes DS_n[3:0], DOE), and waits for DTACK_n. It returns a one-cycle ack or bus-error pulse to the local master. Its `dma_aboel`/`dma_aboeh` and cycle outputs feed the buffer-control logic that steers the address and data buffers during master cycles.

---
 rtl/z3_master_cycle.sv | 205 ++++++++++++++++++++
 tb/tb_z3_master_cycle.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z3_master_cycle.sv
// ---------------------------------------------------------------------------
// z3_master_cycle
//
// Zorro III bus-master cycle sequencer for the A4091 DMA path. One local
// 68030-style transfer request (siz, A1:A0, rd) is turned into a Zorro III
// master cycle: address phase, full cycle strobe, byte strobes with data
// enable, then a wait for DTACK. The local master gets a one-cycle ack, or
// a one-cycle berr pulse if DTACK does not arrive in time.
//
// Parameters
//   ADDR_SETUP     cycles the address is driven before FCS asserts (1..15)
//   DTACK_TIMEOUT  DATA-state cycles without DTACK before a bus error (2..255)
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET_n    in   synchronous active-low reset
//   req        in   local master transfer request, held until ack/berr
//   rd         in   1 = read (Zorro to board), 0 = write
//   siz        in   68030 size: 00 long, 01 byte, 10 word, 11 3-byte
//   addrl      in   A1:A0 of the transfer
//   granted    in   Zorro III bus granted to this board
//   DTACK_n    in   Zorro III data acknowledge (asynchronous)
//   Z_FCS_n    out  full cycle strobe, active low
//   DS_n       out  byte strobes, active low; DS_n[3] = offset 0 (D31:24)
//   z_read     out  Zorro III READ level
//   DOE        out  data output enable
//   dma_aboel  out  low address buffer enable
//   dma_aboeh  out  high address buffer enable
//   ack        out  one-cycle normal completion pulse
//   berr       out  one-cycle DTACK timeout pulse
//   busy       out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module z3_master_cycle #(
   parameter int ADDR_SETUP    = 1,
   parameter int DTACK_TIMEOUT = 255
) (
   input  logic       CLK,
   input  logic       RESET_n,
   input  logic       req,
   input  logic       rd,
   input  logic [1:0] siz,
   input  logic [1:0] addrl,
   input  logic       granted,
   input  logic       DTACK_n,
   output logic       Z_FCS_n,
   output logic [3:0] DS_n,
   output logic       z_read,
   output logic       DOE,
   output logic       dma_aboel,
   output logic       dma_aboeh,
   output logic       ack,
   output logic       berr,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      STRB,
      DATA,
      TERM
   } state_t;

   // Counter terminal values. The ADDR counter starts at zero on entry, so
   // the last ADDR cycle is ADDR_SETUP-1. The timeout counter is compared
   // before it increments, which places berr DTACK_TIMEOUT+1 edges after
   // DATA entry.
   localparam logic [3:0] SETUP_LAST = 4'(ADDR_SETUP - 1);
   localparam logic [7:0] TMO_LAST   = 8'(DTACK_TIMEOUT);

   state_t     state;
   logic [3:0] setup_cnt;
   logic [7:0] tmo_cnt;
   logic [3:0] ds_lat;
   logic       dtack_m;
   logic       dtack_s;

   // Byte-lane encode: offsets addrl .. addrl+n-1 are strobed, where n is
   // the transfer size in bytes (siz=00 means 4). Anything beyond offset 3
   // falls outside this longword and is dropped.
   function automatic logic [3:0] lane_encode(input logic [1:0] sz,
                                              input logic [1:0] off);
      logic [2:0] n;
      logic [3:0] end_off;
      logic [3:0] pat;
      n       = (sz == 2'b00) ? 3'd4 : {1'b0, sz};
      end_off = {2'b00, off} + {1'b0, n};
      pat     = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         if ((4'(k) >= {2'b00, off}) && (4'(k) < end_off)) begin
            pat[2'(3 - k)] = 1'b0;
         end
      end
      return pat;
   endfunction

   // Two-flop synchronizer for the asynchronous DTACK_n. Resets to the
   // deasserted level so a reset can never look like an acknowledge.
   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         dtack_m <= 1'b1;
         dtack_s <= 1'b1;
      end else begin
         dtack_m <= DTACK_n;
         dtack_s <= dtack_m;
      end
   end

   // Cycle sequencer. Every bus-facing output is assigned on the same edge
   // that enters the state producing it, so outputs change together with
   // the state register and never glitch. ack/berr default low each cycle
   // and are only raised on the edge that enters TERM.
   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         state     <= IDLE;
         setup_cnt <= '0;
         tmo_cnt   <= '0;
         ds_lat    <= 4'b1111;
         Z_FCS_n   <= 1'b1;
         DS_n      <= 4'b1111;
         z_read    <= 1'b1;
         DOE       <= 1'b0;
         dma_aboel <= 1'b0;
         dma_aboeh <= 1'b0;
         ack       <= 1'b0;
         berr      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ack  <= 1'b0;
         berr <= 1'b0;
         case (state)
            IDLE: begin
               if (req && granted) begin
                  state     <= ADDR;
                  ds_lat    <= lane_encode(siz, addrl);
                  setup_cnt <= '0;
                  z_read    <= rd;
                  dma_aboel <= 1'b1;
                  dma_aboeh <= 1'b1;
                  busy      <= 1'b1;
               end
            end

            ADDR: begin
               if (setup_cnt == SETUP_LAST) begin
                  state   <= STRB;
                  Z_FCS_n <= 1'b0;
               end else begin
                  setup_cnt <= setup_cnt + 4'd1;
               end
            end

            // The high address half is released as soon as FCS has been
            // seen by the slave; the low half stays up until termination.
            STRB: begin
               state     <= DATA;
               DS_n      <= ds_lat;
               DOE       <= 1'b1;
               dma_aboeh <= 1'b0;
               tmo_cnt   <= '0;
            end

            // DTACK has priority over the timeout when both land together.
            DATA: begin
               if (!dtack_s) begin
                  state     <= TERM;
                  ack       <= 1'b1;
                  Z_FCS_n   <= 1'b1;
                  DS_n      <= 4'b1111;
                  DOE       <= 1'b0;
                  dma_aboel <= 1'b0;
                  z_read    <= 1'b1;
               end else if (tmo_cnt == TMO_LAST) begin
                  state     <= TERM;
                  berr      <= 1'b1;
                  Z_FCS_n   <= 1'b1;
                  DS_n      <= 4'b1111;
                  DOE       <= 1'b0;
                  dma_aboel <= 1'b0;
                  z_read    <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            TERM: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state     <= IDLE;
               Z_FCS_n   <= 1'b1;
               DS_n      <= 4'b1111;
               z_read    <= 1'b1;
               DOE       <= 1'b0;
               dma_aboel <= 1'b0;
               dma_aboeh <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_z3_master_cycle.sv
// ---------------------------------------------------------------------------
// tb_z3_master_cycle
//
// Self-checking bench for z3_master_cycle. Two instances are used: dut_a
// with ADDR_SETUP=1 and dut_b with ADDR_SETUP=3, both with DTACK_TIMEOUT=8.
// A select bit routes req/granted to one instance at a time and picks which
// instance's outputs are observed. Expected outputs come from a timeline
// model: given the accept edge, setup length, DTACK arrival and timeout, it
// says what every output must be at each edge.
// ---------------------------------------------------------------------------
module tb_z3_master_cycle;

   localparam int TMO = 8;
   localparam logic [11:0] IDLE_VEC = 12'b1_1111_1_0_0_0_0_0_0;

   logic       CLK = 1'b0;
   logic       RESET_n = 1'b0;
   logic       sel = 1'b0;
   logic       req = 1'b0;
   logic       rd = 1'b0;
   logic [1:0] siz = 2'b00;
   logic [1:0] addrl = 2'b00;
   logic       granted = 1'b0;
   logic       DTACK_n = 1'b1;

   logic       fcs_a, doe_a, zr_a, el_a, eh_a, ack_a, berr_a, busy_a;
   logic       fcs_b, doe_b, zr_b, el_b, eh_b, ack_b, berr_b, busy_b;
   logic [3:0] ds_a, ds_b;
   logic       req_a, req_b, gnt_a, gnt_b;
   logic [11:0] vec_a, vec_b;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   assign req_a = req & ~sel;
   assign gnt_a = granted & ~sel;
   assign req_b = req & sel;
   assign gnt_b = granted & sel;

   assign vec_a = {fcs_a, ds_a, zr_a, doe_a, el_a, eh_a, ack_a, berr_a, busy_a};
   assign vec_b = {fcs_b, ds_b, zr_b, doe_b, el_b, eh_b, ack_b, berr_b, busy_b};

   z3_master_cycle #(.ADDR_SETUP(1), .DTACK_TIMEOUT(TMO)) dut_a (
      .CLK(CLK), .RESET_n(RESET_n), .req(req_a), .rd(rd), .siz(siz),
      .addrl(addrl), .granted(gnt_a), .DTACK_n(DTACK_n),
      .Z_FCS_n(fcs_a), .DS_n(ds_a), .z_read(zr_a), .DOE(doe_a),
      .dma_aboel(el_a), .dma_aboeh(eh_a), .ack(ack_a), .berr(berr_a),
      .busy(busy_a)
   );

   z3_master_cycle #(.ADDR_SETUP(3), .DTACK_TIMEOUT(TMO)) dut_b (
      .CLK(CLK), .RESET_n(RESET_n), .req(req_b), .rd(rd), .siz(siz),
      .addrl(addrl), .granted(gnt_b), .DTACK_n(DTACK_n),
      .Z_FCS_n(fcs_b), .DS_n(ds_b), .z_read(zr_b), .DOE(doe_b),
      .dma_aboel(el_b), .dma_aboeh(eh_b), .ack(ack_b), .berr(berr_b),
      .busy(busy_b)
   );

   // Strobe pattern from the size/offset rule: a run of n ones shifted to
   // the start offset gives the lanes in offset order; offset 0 is DS_n[3].
   function automatic logic [3:0] model_pattern(input logic [1:0] s,
                                                input logic [1:0] a);
      int n;
      logic [7:0] mask;
      n = (s == 2'b00) ? 4 : int'(s);
      mask = 8'(((1 << n) - 1) << int'(a));
      return ~{mask[0], mask[1], mask[2], mask[3]};
   endfunction

   // Output timeline relative to the accept edge (t = 0). s is the setup
   // length, tt the terminating edge, isack selects ack or berr there.
   function automatic logic [11:0] exp_vec(input int t, input int s,
                                           input int tt, input logic r,
                                           input logic [3:0] pat,
                                           input logic isack);
      int d;
      logic fcs, zr, doe, el, eh, a, b, bz;
      logic [3:0] ds;
      d   = s + 1;
      fcs = !(t >= s && t < tt);
      ds  = (t >= d && t < tt) ? pat : 4'hF;
      zr  = (t < tt) ? r : 1'b1;
      doe = (t >= d && t < tt);
      el  = (t < tt);
      eh  = (t < d);
      a   = (t == tt) && isack;
      b   = (t == tt) && !isack;
      bz  = (t <= tt);
      return {fcs, ds, zr, doe, el, eh, a, b, bz};
   endfunction

   // One complete master cycle on the selected instance. DTACK_n is driven
   // low just after edge xrel (xrel < 0: never). With keep_req set, req
   // stays high so the next call is accepted straight out of IDLE.
   task automatic run_transfer(input logic b, input logic r,
                               input logic [1:0] s, input logic [1:0] a,
                               input int xrel, input logic keep_req,
                               input string name);
      int setup, d, tt, ta;
      logic isack;
      logic [3:0] pat;
      logic [11:0] obs, exp;
      setup = b ? 3 : 1;
      d     = setup + 1;
      pat   = model_pattern(s, a);
      ta    = (xrel + 3 > d + 1) ? xrel + 3 : d + 1;
      isack = (xrel >= 0) && (ta <= d + TMO + 1);
      tt    = isack ? ta : d + TMO + 1;
      sel = b; rd = r; siz = s; addrl = a; req = 1'b1; granted = 1'b1;
      for (int t = 0; t <= tt + 1; t++) begin
         @(posedge CLK);
         #1;
         if (t == xrel && t < tt) DTACK_n = 1'b0;
         if (t == tt) begin
            DTACK_n = 1'b1;
            if (!keep_req) req = 1'b0;
         end
         obs = b ? vec_b : vec_a;
         exp = exp_vec(t, setup, tt, r, pat, isack);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0d siz=%b addrl=%b: got %b expected %b",
                     name, t, s, a, obs, exp);
         end
      end
   endtask

   // Reset holds every output of both instances at its idle level.
   task automatic test_reset();
      RESET_n = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (vec_a !== IDLE_VEC) begin
         errors++;
         $display("[TB] FAIL reset_a: got %b expected %b", vec_a, IDLE_VEC);
      end
      checks++;
      if (vec_b !== IDLE_VEC) begin
         errors++;
         $display("[TB] FAIL reset_b: got %b expected %b", vec_b, IDLE_VEC);
      end
      RESET_n = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   // Long read, DTACK two cycles after the strobes appear.
   task automatic test_long_read();
      run_transfer(1'b0, 1'b1, 2'b00, 2'b00, 4, 1'b0, "long_read");
   endtask

   // All size/offset combinations as writes with a prompt DTACK.
   task automatic test_byte_lanes();
      for (int i = 0; i < 16; i++) begin
         run_transfer(1'b0, 1'b0, 2'(i >> 2), 2'(i), 2, 1'b0, "byte_lanes");
      end
   endtask

   // Request without grant must not start anything; grant starts it on
   // the very next edge.
   task automatic test_grant_gating();
      sel = 1'b0; rd = 1'b1; siz = 2'b10; addrl = 2'b00;
      req = 1'b1; granted = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         #1;
         checks++;
         if (vec_a !== IDLE_VEC) begin
            errors++;
            $display("[TB] FAIL grant_gating cycle %0d: got %b expected %b",
                     i, vec_a, IDLE_VEC);
         end
      end
      run_transfer(1'b0, 1'b1, 2'b10, 2'b00, 3, 1'b0, "grant_start");
   endtask

   // DTACK never arrives: berr once, DTACK_TIMEOUT+1 edges into DATA.
   task automatic test_timeout();
      run_transfer(1'b0, 1'b1, 2'b00, 2'b00, -1, 1'b0, "timeout_a");
      run_transfer(1'b1, 1'b0, 2'b01, 2'b10, -1, 1'b0, "timeout_b");
   endtask

   // Reset while in DATA with DTACK held off: outputs drop at the reset
   // edge and no late berr ever follows.
   task automatic test_reset_mid_cycle();
      sel = 1'b0; rd = 1'b0; siz = 2'b00; addrl = 2'b00;
      req = 1'b1; granted = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (vec_a !== exp_vec(2, 1, 100, 1'b0, 4'b0000, 1'b1)) begin
         errors++;
         $display("[TB] FAIL reset_mid_data_state: got %b", vec_a);
      end
      RESET_n = 1'b0;
      req = 1'b0;
      @(posedge CLK);
      #1;
      RESET_n = 1'b1;
      checks++;
      if (vec_a !== IDLE_VEC) begin
         errors++;
         $display("[TB] FAIL reset_mid_cycle: got %b expected %b",
                  vec_a, IDLE_VEC);
      end
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK);
         #1;
         checks++;
         if (vec_a !== IDLE_VEC) begin
            errors++;
            $display("[TB] FAIL reset_aftermath cycle %0d: got %b expected %b",
                     i, vec_a, IDLE_VEC);
         end
      end
   endtask

   // ADDR_SETUP=3 instance with req held: second accept right out of IDLE.
   task automatic test_back_to_back();
      run_transfer(1'b1, 1'b1, 2'b00, 2'b00, 5, 1'b1, "b2b_first");
      run_transfer(1'b1, 1'b0, 2'b11, 2'b01, 4, 1'b0, "b2b_second");
   endtask

   // Random instance, direction, size, offset and DTACK arrival; late
   // arrivals past the timeout window turn into bus errors.
   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         logic b;
         int x;
         b = 1'($urandom_range(0, 1));
         x = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 16));
         run_transfer(b, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), x,
                      1'($urandom_range(0, 1)), "random");
      end
      req = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      test_reset();
      test_long_read();
      test_byte_lanes();
      test_grant_gating();
      test_timeout();
      test_reset_mid_cycle();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
